// File: rtl/timing_pkg.sv
// Shared constants for the display/audio timing counters.
// Direction encodings and default widths used by every counter instance.
package timing_pkg;

    localparam logic CNT_UP   = 1'b0;
    localparam logic CNT_DOWN = 1'b1;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_WRAP_W = 8;

endpackage

// File: rtl/rise_toggle.sv
// Rising-edge toggle: each 0->1 transition of `in` flips `state`.
// Reusable for any push-button style toggle sampled in the clk domain.
module rise_toggle (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic state
);

    logic in_q;
    logic rise;

    assign rise = in & ~in_q;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_q  <= 1'b0;
            state <= 1'b0;
        end else begin
            in_q  <= in;
            state <= state ^ rise;
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Programmable-modulus up/down counter with synchronous load, pause toggle,
// a one-cycle wrap pulse and a running wrap tally.
module mod_counter
    import timing_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int WRAP_W  = DEF_WRAP_W,
    parameter bit DOWN_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              pause,
    input  logic              dir,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [WIDTH-1:0]  reset_at,
    output logic [WIDTH-1:0]  count,
    output logic              paused,
    output logic              at_limit,
    output logic              wrap,
    output logic [WRAP_W-1:0] wrap_cnt
);

    logic [WIDTH-1:0] limit;
    logic             count_down;
    logic             step;

    rise_toggle u_pause (
        .clk   (clk),
        .reset (reset),
        .in    (pause),
        .state (paused)
    );

    assign count_down = DOWN_EN && (dir == CNT_DOWN);
    // paused is the pre-toggle value here, so a rise still lets this edge step.
    assign step       = en & ~paused;

    // NOTE: every always_comb output gets a value on all paths to avoid inferring a latch.
    always_comb begin
        limit = (reset_at == '0) ? '1 : reset_at - WIDTH'(1);
    end

    assign at_limit = count_down ? (count == '0) : (count == limit);

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            wrap     <= 1'b0;
            wrap_cnt <= '0;
        end else if (load) begin
            count <= (load_val > limit) ? limit : load_val;
            wrap  <= 1'b0;
        end else if (step) begin
            if (count_down) begin
                if (count == '0) begin
                    count    <= limit;
                    wrap     <= 1'b1;
                    wrap_cnt <= wrap_cnt + WRAP_W'(1);
                end else if (count > limit) begin
                    // Stranded above a lowered modulus: snap to limit without a wrap.
                    count <= limit;
                    wrap  <= 1'b0;
                end else begin
                    count <= count - WIDTH'(1);
                    wrap  <= 1'b0;
                end
            end else begin
                if (count >= limit) begin
                    count    <= '0;
                    wrap     <= 1'b1;
                    wrap_cnt <= wrap_cnt + WRAP_W'(1);
                end else begin
                    count <= count + WIDTH'(1);
                    wrap  <= 1'b0;
                end
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: a vector table for single-cycle behaviour
// plus hand sequences for pause, down-wrap and reset corner cases.
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       reset, en, pause, dir, load;
    logic [7:0] load_val, reset_at;
    logic [7:0] count;
    logic       paused, at_limit, wrap;
    logic [7:0] wrap_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        logic       rst, en, pau, dir, ld;
        logic [7:0] lv, ra;
        logic [7:0] e_cnt;
        logic       e_psd, e_wr;
        logic [7:0] e_wc;
        logic       e_al;
    } vec_t;

    vec_t tbl[$];

    mod_counter #(.WIDTH(8), .WRAP_W(8), .DOWN_EN(1'b1)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .pause    (pause),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .reset_at (reset_at),
        .count    (count),
        .paused   (paused),
        .at_limit (at_limit),
        .wrap     (wrap),
        .wrap_cnt (wrap_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs, then sample outputs 1 time unit after the next rising edge.
    task automatic cyc(input logic r, input logic e, input logic p, input logic d,
                       input logic l, input logic [7:0] lv, input logic [7:0] ra);
        reset = r; en = e; pause = p; dir = d; load = l; load_val = lv; reset_at = ra;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [7:0] c, input logic p,
                              input logic w, input logic [7:0] wc, input logic al);
        check({name, ".count"},    32'(count),    32'(c));
        check({name, ".paused"},   32'(paused),   32'(p));
        check({name, ".wrap"},     32'(wrap),     32'(w));
        check({name, ".wrap_cnt"}, 32'(wrap_cnt), 32'(wc));
        check({name, ".at_limit"}, 32'(at_limit), 32'(al));
    endtask

    function automatic vec_t mk(string n, logic r, logic e, logic p, logic d, logic l,
                                logic [7:0] lv, logic [7:0] ra, logic [7:0] c,
                                logic ps, logic w, logic [7:0] wc, logic al);
        vec_t v;
        v.name = n; v.rst = r; v.en = e; v.pau = p; v.dir = d; v.ld = l;
        v.lv = lv; v.ra = ra; v.e_cnt = c; v.e_psd = ps; v.e_wr = w; v.e_wc = wc; v.e_al = al;
        return v;
    endfunction

    initial begin
        //                 name       rst en pau dir ld  lv   ra   cnt ps wr wc al
        tbl.push_back(mk("reset",     1, 0, 0, 0, 0,   0,   5,   0, 0, 0, 0, 0));
        tbl.push_back(mk("up5_1",     0, 1, 0, 0, 0,   0,   5,   1, 0, 0, 0, 0));
        tbl.push_back(mk("up5_2",     0, 1, 0, 0, 0,   0,   5,   2, 0, 0, 0, 0));
        tbl.push_back(mk("up5_3",     0, 1, 0, 0, 0,   0,   5,   3, 0, 0, 0, 0));
        tbl.push_back(mk("up5_4",     0, 1, 0, 0, 0,   0,   5,   4, 0, 0, 0, 1));
        tbl.push_back(mk("up5_wrap1", 0, 1, 0, 0, 0,   0,   5,   0, 0, 1, 1, 0));
        tbl.push_back(mk("up5_1b",    0, 1, 0, 0, 0,   0,   5,   1, 0, 0, 1, 0));
        tbl.push_back(mk("up5_2b",    0, 1, 0, 0, 0,   0,   5,   2, 0, 0, 1, 0));
        tbl.push_back(mk("up5_3b",    0, 1, 0, 0, 0,   0,   5,   3, 0, 0, 1, 0));
        tbl.push_back(mk("up5_4b",    0, 1, 0, 0, 0,   0,   5,   4, 0, 0, 1, 1));
        tbl.push_back(mk("up5_wrap2", 0, 1, 0, 0, 0,   0,   5,   0, 0, 1, 2, 0));
        tbl.push_back(mk("up5_1c",    0, 1, 0, 0, 0,   0,   5,   1, 0, 0, 2, 0));
        tbl.push_back(mk("ld200",     0, 0, 0, 0, 1, 200,   0, 200, 0, 0, 2, 0));
        tbl.push_back(mk("strand_up", 0, 1, 0, 0, 0,   0,   8,   0, 0, 1, 3, 0));
        tbl.push_back(mk("ld200b",    0, 0, 0, 1, 1, 200,   0, 200, 0, 0, 3, 0));
        tbl.push_back(mk("strand_dn", 0, 1, 0, 1, 0,   0,   8,   7, 0, 0, 3, 0));
        tbl.push_back(mk("ld_clamp",  0, 0, 0, 0, 1,   9,   6,   5, 0, 0, 3, 1));
        tbl.push_back(mk("ld_vs_en",  0, 1, 0, 0, 1,   1,   6,   1, 0, 0, 3, 0));
        tbl.push_back(mk("rise_step", 0, 1, 1, 0, 0,   0,   6,   2, 1, 0, 3, 0));
        tbl.push_back(mk("ld_paused", 0, 0, 0, 0, 1,   3,   6,   3, 1, 0, 3, 0));
        tbl.push_back(mk("hold_psd",  0, 1, 0, 0, 0,   0,   6,   3, 1, 0, 3, 0));

        foreach (tbl[i]) begin
            cyc(tbl[i].rst, tbl[i].en, tbl[i].pau, tbl[i].dir, tbl[i].ld, tbl[i].lv, tbl[i].ra);
            expect_out(tbl[i].name, tbl[i].e_cnt, tbl[i].e_psd, tbl[i].e_wr, tbl[i].e_wc, tbl[i].e_al);
        end

        // Down count with reset_at=0 (modulus 256).
        cyc(1, 0, 0, 1, 0, 0, 0);
        expect_out("dn_reset", 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 1, 0, 0, 0);
        expect_out("dn_wrap", 255, 0, 1, 1, 0);
        cyc(0, 1, 0, 1, 0, 0, 0);
        expect_out("dn_254", 254, 0, 0, 1, 0);
        cyc(0, 1, 0, 1, 0, 0, 0);
        expect_out("dn_253", 253, 0, 0, 1, 0);

        // Pause pulses and a long pause level.
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 0);
        expect_out("p_at3", 3, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0);
        expect_out("p_rise", 4, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 0);
        expect_out("p_hold", 4, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0);
        expect_out("p_unpause", 4, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        expect_out("p_resume", 5, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0);
        expect_out("p_level1", 6, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) cyc(0, 1, 1, 0, 0, 0, 0);
        expect_out("p_level10", 6, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        expect_out("p_release", 6, 1, 0, 0, 0);

        // reset_at=1: every step wraps, up and down.
        cyc(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 1);
        expect_out("ra1_up", 0, 0, 1, 3, 1);
        cyc(0, 1, 0, 1, 0, 0, 1);
        expect_out("ra1_dn", 0, 0, 1, 4, 1);

        // Reset mid-operation clears everything; counting resumes unpaused.
        cyc(0, 0, 1, 0, 1, 3, 0);
        expect_out("pre_rst", 3, 1, 0, 4, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        expect_out("mid_rst", 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        expect_out("post_rst1", 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        expect_out("post_rst2", 2, 0, 0, 0, 0);

        // Pause held high through reset registers one rise right after reset.
        cyc(1, 0, 1, 0, 0, 0, 0);
        expect_out("held_rst", 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0);
        expect_out("held_rise", 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0);
        expect_out("held_stay", 1, 1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
